lifo_stack: RTL and testbench

- Parametrised, depth-checked LIFO stack. Successor to the single-pointer LIFO in the same buffering library.
- Adds the following over the earlier block:
  - registered pop data with a one-cycle valid strobe;
  - true empty, full and almost-full flags and an occupancy count;
  - defined push+pop-in-same-cycle semantics;
  - sticky overflow and underflow error flags;
  - a synchronous clear.
- Sits between a producer and a consumer that need last-in-first-out reordering, e.g. undo/backtrack buffers.

---
 rtl/lifo_stack.sv | 136 +++++++++++++
 tb/tb_lifo_stack.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised last-in-first-out stack with registered pop data,
// occupancy flags, sticky overflow/underflow errors and a synchronous clear.
// A simultaneous push and pop swaps the top entry (or bypasses when empty).
module lifo_stack #(
   parameter int DATA_W   = 10,
   parameter int DEPTH    = 6,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] datain,
   input  logic              pop,
   input  logic              clear,
   output logic [DATA_W-1:0] dataout,
   output logic              val,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   // Storage index width; count is one bit wider when DEPTH is a power of two.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              val_q, val_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              is_empty;
   logic              is_full;
   logic [CNT_W-1:0]  cnt_m1;
   logic [AW-1:0]     top_idx;
   logic [AW-1:0]     push_idx;
   logic [DATA_W-1:0] top_word;

   logic              wr_en;
   logic [AW-1:0]     wr_idx;
   logic [DATA_W-1:0] wr_data;

   // Occupancy decode and top-of-stack addressing.
   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == CNT_W'(DEPTH));
      cnt_m1   = count_q - CNT_W'(1);
      top_idx  = cnt_m1[AW-1:0];
      push_idx = count_q[AW-1:0];
      // The top entry only exists when the stack holds something.
      top_word = is_empty ? '0 : mem[top_idx];
   end

   // Per-edge operation select: clear first, then the push/pop cases.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = push_idx;
      wr_data = datain;
      count_d = count_q;
      dout_d  = dout_q;
      val_d   = 1'b0;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else if (push && !pop) begin
         if (!is_full) begin
            wr_en   = 1'b1;
            wr_idx  = push_idx;
            count_d = count_q + CNT_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end else if (pop && !push) begin
         if (!is_empty) begin
            dout_d  = top_word;
            count_d = cnt_m1;
            val_d   = 1'b1;
         end else begin
            udf_d = 1'b1;
         end
      end else if (push && pop) begin
         val_d = 1'b1;
         if (!is_empty) begin
            // Swap-top: old top goes out, new word replaces it in place.
            dout_d = top_word;
            wr_en  = 1'b1;
            wr_idx = top_idx;
         end else begin
            // Bypass: the pushed word passes straight through.
            dout_d = datain;
         end
      end
   end

   // Control and output registers, cleared by the asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         dout_q  <= '0;
         val_q   <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         val_q   <= val_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage array write; contents are deliberately left unreset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign dataout     = dout_q;
   assign val         = val_q;
   assign count       = count_q;
   assign empty       = is_empty;
   assign full        = is_full;
   assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios for lifo_stack with hand-computed expectations.
module tb_lifo_stack;

   logic       clock;
   logic       reset;
   logic       push;
   logic [9:0] datain;
   logic       pop;
   logic       clear;
   logic [9:0] dataout;
   logic       val;
   logic [2:0] count;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   lifo_stack dut (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .datain      (datain),
      .pop         (pop),
      .clear       (clear),
      .dataout     (dataout),
      .val         (val),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic p, input logic q, input logic [9:0] d);
      push   = p;
      pop    = q;
      datain = d;
      clear  = 1'b0;
      tick();
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      push = 1'b0; pop = 1'b0; clear = 1'b0; datain = '0;
      #12;
      checks++;
      if ({count, empty, full, almost_full, val, overflow, underflow} !== {3'd0, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL reset_flags: got cnt=%0d e=%b f=%b af=%b v=%b ov=%b un=%b exp cnt=0 e=1 others 0",
                  count, empty, full, almost_full, val, overflow, underflow);
      end
      checks++;
      if (dataout !== 10'h000) begin
         errors++; $display("FAIL reset_dataout: got %h exp 000", dataout);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_push_pop();
      logic [9:0] exp_d;
      drive(1, 0, 10'd1);
      drive(1, 0, 10'd2);
      drive(1, 0, 10'd3);
      checks++;
      if (count !== 3'd3) begin errors++; $display("FAIL pp_count3: got %0d exp 3", count); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 10'd0);
         exp_d = 10'(3 - i);
         checks++;
         if (dataout !== exp_d || val !== 1'b1 || count !== 3'(2 - i)) begin
            errors++;
            $display("FAIL pp_pop%0d: got d=%h v=%b cnt=%0d exp d=%h v=1 cnt=%0d",
                     i, dataout, val, count, exp_d, 2 - i);
         end
      end
      drive(0, 0, 10'd0);
      checks++;
      if (val !== 1'b0 || empty !== 1'b1) begin
         errors++; $display("FAIL pp_idle: got v=%b e=%b exp v=0 e=1", val, empty);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 10'h101 + 10'(i));
         checks++;
         if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 5) || full !== (i + 1 == 6)) begin
            errors++;
            $display("FAIL fill%0d: got cnt=%0d af=%b f=%b exp cnt=%0d af=%b f=%b",
                     i, count, almost_full, full, i + 1, (i + 1 >= 5), (i + 1 == 6));
         end
      end
      drive(1, 0, 10'h3FF);
      checks++;
      if (count !== 3'd6 || overflow !== 1'b1 || val !== 1'b0 || full !== 1'b1) begin
         errors++;
         $display("FAIL ovf_push: got cnt=%0d ov=%b v=%b f=%b exp cnt=6 ov=1 v=0 f=1",
                  count, overflow, val, full);
      end
   endtask

   task automatic test_underflow_clear();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 10'd0);
         checks++;
         if (dataout !== 10'h106 - 10'(i) || val !== 1'b1 || count !== 3'(5 - i)) begin
            errors++;
            $display("FAIL drain%0d: got d=%h v=%b cnt=%0d exp d=%h v=1 cnt=%0d",
                     i, dataout, val, count, 10'h106 - 10'(i), 5 - i);
         end
      end
      drive(0, 1, 10'd0);
      checks++;
      if (underflow !== 1'b1 || val !== 1'b0 || dataout !== 10'h101 || count !== 3'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL udf_pop: got un=%b v=%b d=%h cnt=%0d ov=%b exp un=1 v=0 d=101 cnt=0 ov=1",
                  underflow, val, dataout, count, overflow);
      end
      push = 1'b1; datain = 10'h077; clear = 1'b1;
      tick();
      push = 1'b0; clear = 1'b0;
      checks++;
      if (underflow !== 1'b0 || overflow !== 1'b0 || count !== 3'd0 || dataout !== 10'h101 || val !== 1'b0) begin
         errors++;
         $display("FAIL clear: got un=%b ov=%b cnt=%0d d=%h v=%b exp un=0 ov=0 cnt=0 d=101 v=0",
                  underflow, overflow, count, dataout, val);
      end
   endtask

   task automatic test_swap();
      drive(1, 0, 10'h055);
      drive(1, 0, 10'h0AA);
      drive(1, 1, 10'h155);
      checks++;
      if (dataout !== 10'h0AA || val !== 1'b1 || count !== 3'd2) begin
         errors++;
         $display("FAIL swap: got d=%h v=%b cnt=%0d exp d=0aa v=1 cnt=2", dataout, val, count);
      end
      drive(0, 1, 10'd0);
      checks++;
      if (dataout !== 10'h155 || count !== 3'd1) begin
         errors++; $display("FAIL swap_pop1: got d=%h cnt=%0d exp d=155 cnt=1", dataout, count);
      end
      drive(0, 1, 10'd0);
      checks++;
      if (dataout !== 10'h055 || count !== 3'd0) begin
         errors++; $display("FAIL swap_pop2: got d=%h cnt=%0d exp d=055 cnt=0", dataout, count);
      end
   endtask

   task automatic test_bypass();
      drive(1, 1, 10'h123);
      checks++;
      if (dataout !== 10'h123 || val !== 1'b1 || count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL bypass: got d=%h v=%b cnt=%0d ov=%b un=%b exp d=123 v=1 cnt=0 ov=0 un=0",
                  dataout, val, count, overflow, underflow);
      end
      for (int i = 0; i < 6; i++) drive(1, 0, 10'h201 + 10'(i));
      drive(1, 1, 10'h2AA);
      checks++;
      if (dataout !== 10'h206 || val !== 1'b1 || count !== 3'd6 || full !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL swap_full: got d=%h v=%b cnt=%0d f=%b ov=%b exp d=206 v=1 cnt=6 f=1 ov=0",
                  dataout, val, count, full, overflow);
      end
      drive(0, 1, 10'd0);
      checks++;
      if (dataout !== 10'h2AA || count !== 3'd5) begin
         errors++; $display("FAIL swap_full_pop: got d=%h cnt=%0d exp d=2aa cnt=5", dataout, count);
      end
   endtask

   task automatic test_async_reset();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 5; i++) drive(1, 0, 10'h300 + 10'(i));
      drive(0, 1, 10'd0);
      checks++;
      if (count !== 3'd4 || val !== 1'b1 || dataout !== 10'h304) begin
         errors++; $display("FAIL pre_areset: got cnt=%0d v=%b d=%h exp cnt=4 v=1 d=304", count, val, dataout);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || val !== 1'b0 || dataout !== 10'h000 || empty !== 1'b1 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL areset: got cnt=%0d v=%b d=%h e=%b af=%b exp cnt=0 v=0 d=000 e=1 af=0",
                  count, val, dataout, empty, almost_full);
      end
      #2 reset = 1'b1;
      drive(0, 1, 10'd0);
      checks++;
      if (underflow !== 1'b1 || val !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL post_areset_pop: got un=%b v=%b cnt=%0d exp un=1 v=0 cnt=0", underflow, val, count);
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_fill_overflow();
      test_underflow_clear();
      test_swap();
      test_bypass();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

endmodule
